// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates tags at issue, captures broadcast results, retires head in order.
// Latency: result captured at edge k, head retires at edge k+1; commit/flush outputs are registered pulses.
// Backpressure: full asserts at 2**ROB_WIDTH-1 entries (one slot of margin); an issue with the buffer completely full is dropped.
//
// Ports:
//   clockIn, resetIn          clock, synchronous active-low reset
//   issue*                    allocate an entry at tail; issueRobId is the tag it receives; full = stop issuing
//   rs*/lsb*                  result broadcast buses (LSB wins on a same-tag collision)
//   queryId*/queryReady*/queryVal*  combinational operand lookup on registered state
//   commit*/storeCommit       register write / store release for the retiring head entry
//   flush/flushPc             branch mispredict recovery pulse and redirect PC
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueRobId,
    output logic                 full,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobId,
    input  logic [31:0]          rsVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobId,
    input  logic [31:0]          lsbVal,
    input  logic [ROB_WIDTH-1:0] queryId1,
    input  logic [ROB_WIDTH-1:0] queryId2,
    output logic                 queryReady1,
    output logic                 queryReady2,
    output logic [31:0]          queryVal1,
    output logic [31:0]          queryVal2,
    output logic                 commitValid,
    output logic [ROB_WIDTH-1:0] commitRobId,
    output logic [4:0]           commitRd,
    output logic [31:0]          commitVal,
    output logic                 storeCommit,
    output logic                 flush,
    output logic [31:0]          flushPc
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] CNT_MAX  = (ROB_WIDTH+1)'(DEPTH);
    localparam logic [ROB_WIDTH:0] FULL_LVL = (ROB_WIDTH+1)'(DEPTH - 1);

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    // Pointers and occupancy
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    // Per-entry state
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     ready_q, ready_d;
    logic [DEPTH-1:0]     pred_q,  pred_d;
    logic [1:0]           type_q  [DEPTH];
    logic [1:0]           type_d  [DEPTH];
    logic [4:0]           rd_q    [DEPTH];
    logic [4:0]           rd_d    [DEPTH];
    logic [31:0]          altpc_q [DEPTH];
    logic [31:0]          altpc_d [DEPTH];
    logic [31:0]          value_q [DEPTH];
    logic [31:0]          value_d [DEPTH];

    // Registered retirement outputs
    logic                 commit_valid_q, commit_valid_d;
    logic [ROB_WIDTH-1:0] commit_rob_id_q, commit_rob_id_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic                 store_commit_q, store_commit_d;
    logic                 flush_q, flush_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic                 retire;
    logic                 mispredict;
    logic                 issue_ok;

    // Retirement looks only at registered state, so a result captured this
    // cycle cannot retire before the next edge.
    assign retire     = valid_q[head_q] && ready_q[head_q];
    assign mispredict = retire && (type_q[head_q] == TYPE_BRANCH)
                        && (value_q[head_q][0] != pred_q[head_q]);
    assign issue_ok   = issueValid && (count_q != CNT_MAX);

    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        valid_d         = valid_q;
        ready_d         = ready_q;
        pred_d          = pred_q;
        type_d          = type_q;
        rd_d            = rd_q;
        altpc_d         = altpc_q;
        value_d         = value_q;
        commit_valid_d  = 1'b0;
        store_commit_d  = 1'b0;
        flush_d         = 1'b0;
        commit_rob_id_d = commit_rob_id_q;
        commit_rd_d     = commit_rd_q;
        commit_val_d    = commit_val_q;
        flush_pc_d      = flush_pc_q;

        // Result capture; LSB is applied second so it wins a tag collision.
        if (rsUpdate && valid_q[rsRobId]) begin
            ready_d[rsRobId] = 1'b1;
            value_d[rsRobId] = rsVal;
        end
        if (lsbUpdate && valid_q[lsbRobId]) begin
            ready_d[lsbRobId] = 1'b1;
            value_d[lsbRobId] = lsbVal;
        end

        // Allocation. Tail can only alias a valid entry when completely full,
        // and that case is excluded by issue_ok.
        if (issue_ok) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            pred_d[tail_q]  = issuePredTaken;
            altpc_d[tail_q] = issueAltPc;
            if (issueType == 2'd3) begin
                // Reserved encoding retires as a register write to x0.
                type_d[tail_q] = TYPE_REG;
                rd_d[tail_q]   = 5'd0;
            end else begin
                type_d[tail_q] = issueType;
                rd_d[tail_q]   = issueRd;
            end
            tail_d = tail_q + 1'b1;
        end

        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            commit_rob_id_d = head_q;
            case (type_q[head_q])
                TYPE_STORE: begin
                    store_commit_d = 1'b1;
                end
                TYPE_BRANCH: begin
                    // Correctly predicted branches retire without a pulse.
                end
                default: begin
                    commit_valid_d = 1'b1;
                    commit_rd_d    = rd_q[head_q];
                    commit_val_d   = value_q[head_q];
                end
            endcase
        end

        count_d = count_q + {{ROB_WIDTH{1'b0}}, issue_ok} - {{ROB_WIDTH{1'b0}}, retire};

        // Mispredict overrides everything above, including a same-cycle issue.
        if (mispredict) begin
            valid_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            flush_d    = 1'b1;
            flush_pc_d = altpc_q[head_q];
        end
    end

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            valid_q         <= '0;
            ready_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_rob_id_q <= '0;
            commit_rd_q     <= '0;
            commit_val_q    <= '0;
            store_commit_q  <= 1'b0;
            flush_q         <= 1'b0;
            flush_pc_q      <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            valid_q         <= valid_d;
            ready_q         <= ready_d;
            pred_q          <= pred_d;
            type_q          <= type_d;
            rd_q            <= rd_d;
            altpc_q         <= altpc_d;
            value_q         <= value_d;
            commit_valid_q  <= commit_valid_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q     <= commit_rd_d;
            commit_val_q    <= commit_val_d;
            store_commit_q  <= store_commit_d;
            flush_q         <= flush_d;
            flush_pc_q      <= flush_pc_d;
        end
    end

    assign issueRobId  = tail_q;
    assign full        = (count_q >= FULL_LVL);

    assign queryReady1 = valid_q[queryId1] && ready_q[queryId1];
    assign queryReady2 = valid_q[queryId2] && ready_q[queryId2];
    assign queryVal1   = value_q[queryId1];
    assign queryVal2   = value_q[queryId2];

    assign commitValid = commit_valid_q;
    assign commitRobId = commit_rob_id_q;
    assign commitRd    = commit_rd_q;
    assign commitVal   = commit_val_q;
    assign storeCommit = store_commit_q;
    assign flush       = flush_q;
    assign flushPc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios followed by random traffic,
// all checked every cycle against a program-order queue model of the buffer.
module tb_reorder_buffer;

    logic        clockIn, resetIn;
    logic        issueValid;
    logic [1:0]  issueType;
    logic [4:0]  issueRd;
    logic        issuePredTaken;
    logic [31:0] issueAltPc;
    logic [3:0]  issueRobId;
    logic        full;
    logic        rsUpdate;
    logic [3:0]  rsRobId;
    logic [31:0] rsVal;
    logic        lsbUpdate;
    logic [3:0]  lsbRobId;
    logic [31:0] lsbVal;
    logic [3:0]  queryId1, queryId2;
    logic        queryReady1, queryReady2;
    logic [31:0] queryVal1, queryVal2;
    logic        commitValid;
    logic [3:0]  commitRobId;
    logic [4:0]  commitRd;
    logic [31:0] commitVal;
    logic        storeCommit;
    logic        flush;
    logic [31:0] flushPc;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clockIn), .resetIn(resetIn),
        .issueValid(issueValid), .issueType(issueType), .issueRd(issueRd),
        .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .issueRobId(issueRobId), .full(full),
        .rsUpdate(rsUpdate), .rsRobId(rsRobId), .rsVal(rsVal),
        .lsbUpdate(lsbUpdate), .lsbRobId(lsbRobId), .lsbVal(lsbVal),
        .queryId1(queryId1), .queryId2(queryId2),
        .queryReady1(queryReady1), .queryReady2(queryReady2),
        .queryVal1(queryVal1), .queryVal2(queryVal2),
        .commitValid(commitValid), .commitRobId(commitRobId),
        .commitRd(commitRd), .commitVal(commitVal),
        .storeCommit(storeCommit), .flush(flush), .flushPc(flushPc)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model: entries in program order ----------------
    typedef struct {
        logic [3:0]  id;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        logic        rdy;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_tail = '0;
    logic        e_cv = 0, e_sc = 0, e_fl = 0;
    logic [3:0]  e_id = '0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_val = '0, e_pc = '0;

    // Step 4 in-order/wrap tracking
    logic        track = 0;
    logic [3:0]  exp_next = 4'd1;
    int          ncommit = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   ret;
        ent_t h;
        ent_t n;
        if (!resetIn) begin
            mq.delete();
            m_tail = '0;
            e_cv = 0; e_sc = 0; e_fl = 0;
            e_id = '0; e_rd = '0; e_val = '0; e_pc = '0;
            return;
        end
        ret = (mq.size() > 0) && mq[0].rdy;
        if (ret) h = mq[0];
        e_cv = 0; e_sc = 0; e_fl = 0;
        foreach (mq[i]) if (rsUpdate && mq[i].id == rsRobId) begin
            mq[i].rdy = 1; mq[i].val = rsVal;
        end
        foreach (mq[i]) if (lsbUpdate && mq[i].id == lsbRobId) begin
            mq[i].rdy = 1; mq[i].val = lsbVal;
        end
        if (issueValid && mq.size() < 16) begin
            n.id   = m_tail;
            n.typ  = (issueType == 2'd3) ? 2'd0 : issueType;
            n.rd   = (issueType == 2'd3) ? 5'd0 : issueRd;
            n.pred = issuePredTaken;
            n.alt  = issueAltPc;
            n.rdy  = 0;
            n.val  = '0;
            mq.push_back(n);
            m_tail = m_tail + 4'd1;
        end
        if (ret) begin
            void'(mq.pop_front());
            e_id = h.id;
            if (h.typ == 2'd1) e_sc = 1;
            else if (h.typ == 2'd2) begin
                if (h.val[0] != h.pred) begin
                    e_fl = 1; e_pc = h.alt;
                    mq.delete(); m_tail = '0;
                end
            end else begin
                e_cv = 1; e_rd = h.rd; e_val = h.val;
            end
        end
    endtask

    function automatic bit m_ready(input logic [3:0] id, output logic [31:0] v);
        v = '0;
        foreach (mq[i]) if (mq[i].id == id && mq[i].rdy) begin
            v = mq[i].val;
            return 1;
        end
        return 0;
    endfunction

    task automatic check_all();
        logic [31:0] v1, v2;
        bit r1, r2;
        r1 = m_ready(queryId1, v1);
        r2 = m_ready(queryId2, v2);
        chk("commitValid", 32'(commitValid), 32'(e_cv));
        chk("storeCommit", 32'(storeCommit), 32'(e_sc));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("commitRd", 32'(commitRd), 32'(e_rd));
        chk("commitVal", commitVal, e_val);
        chk("flushPc", flushPc, e_pc);
        if (e_cv || e_sc) chk("commitRobId", 32'(commitRobId), 32'(e_id));
        chk("issueRobId", 32'(issueRobId), 32'(m_tail));
        chk("full", 32'(full), 32'(mq.size() >= 15));
        chk("queryReady1", 32'(queryReady1), 32'(r1));
        chk("queryReady2", 32'(queryReady2), 32'(r2));
        if (r1) chk("queryVal1", queryVal1, v1);
        if (r2) chk("queryVal2", queryVal2, v2);
    endtask

    task automatic tick();
        model_step();
        @(posedge clockIn);
        #1;
        check_all();
        if (track && commitValid) begin
            chk("t4_wrap_order", 32'(commitRobId), 32'(exp_next));
            exp_next = exp_next + 4'd1;
            ncommit++;
        end
        issueValid = 0; rsUpdate = 0; lsbUpdate = 0;
    endtask

    task automatic do_reset();
        issueValid = 0; rsUpdate = 0; lsbUpdate = 0;
        resetIn = 0;
        tick();
        resetIn = 1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] alt);
        issueValid = 1; issueType = t; issueRd = rd; issuePredTaken = p; issueAltPc = alt;
    endtask

    task automatic rs(input logic [3:0] id, input logic [31:0] v);
        rsUpdate = 1; rsRobId = id; rsVal = v;
    endtask

    task automatic lsb(input logic [3:0] id, input logic [31:0] v);
        lsbUpdate = 1; lsbRobId = id; lsbVal = v;
    endtask

    initial begin
        resetIn = 0; issueValid = 0; issueType = 0; issueRd = 0; issuePredTaken = 0;
        issueAltPc = 0; rsUpdate = 0; rsRobId = 0; rsVal = 0; lsbUpdate = 0;
        lsbRobId = 0; lsbVal = 0; queryId1 = 0; queryId2 = 4'd5;

        // 1: reset held for two cycles
        tick(); tick();
        resetIn = 1;
        chk("t1_issueRobId", 32'(issueRobId), 32'd0);
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_commitRobId", 32'(commitRobId), 32'd0);
        tick();

        // 2: single REG issue, update, commit
        issue(2'd0, 5'd5, 0, 0); tick();
        rs(4'd0, 32'h1234); queryId1 = 4'd0; tick();
        chk("t2_query_ready", 32'(queryReady1), 32'd1);
        chk("t2_no_commit_yet", 32'(commitValid), 32'd0);
        tick();
        chk("t2_cv", 32'(commitValid), 32'd1);
        chk("t2_rd", 32'(commitRd), 32'd5);
        chk("t2_val", commitVal, 32'h1234);
        chk("t2_id", 32'(commitRobId), 32'd0);

        // 3: out-of-order completion, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) begin issue(2'd0, 5'(10 + i), 0, 0); tick(); end
        rs(4'd2, 32'h22); tick();
        lsb(4'd1, 32'hBEEF); tick();
        rs(4'd0, 32'h11); tick();
        tick();
        chk("t3_c0_id", 32'(commitRobId), 32'd0);
        chk("t3_c0_val", commitVal, 32'h11);
        tick();
        chk("t3_c1_id", 32'(commitRobId), 32'd1);
        chk("t3_c1_val", commitVal, 32'hBEEF);
        tick();
        chk("t3_c2_id", 32'(commitRobId), 32'd2);
        chk("t3_c2_cv", 32'(commitValid), 32'd1);

        // 4: fill to full, drain, wrap tags
        do_reset();
        for (int i = 0; i < 15; i++) begin issue(2'd0, 5'(i), 0, 0); tick(); end
        chk("t4_full_set", 32'(full), 32'd1);
        rs(4'd0, 32'h100); tick();
        tick();
        chk("t4_full_clear", 32'(full), 32'd0);
        chk("t4_head_id", 32'(commitRobId), 32'd0);
        track = 1; exp_next = 4'd1; ncommit = 0;
        for (int k = 15; k < 20; k++) begin
            issue(2'd0, 5'(k), 0, 0); rs(4'(k - 14), 32'(k)); tick();
        end
        for (int j = 6; j < 20; j++) begin rs(4'(j % 16), 32'(j + 100)); tick(); end
        for (int j = 0; j < 20; j++) tick();
        track = 0;
        chk("t4_ncommit", 32'(ncommit), 32'd19);

        // 5: mispredicted branch flushes younger entries
        do_reset();
        issue(2'd2, 5'd0, 1, 32'h100); tick();
        for (int i = 0; i < 3; i++) begin issue(2'd0, 5'(i + 1), 0, 0); tick(); end
        rs(4'd1, 32'h1); lsb(4'd2, 32'h2); tick();
        rs(4'd3, 32'h3); tick();
        rs(4'd0, 32'h0); tick();
        issue(2'd0, 5'd9, 0, 0); tick();
        chk("t5_flush", 32'(flush), 32'd1);
        chk("t5_flushPc", flushPc, 32'h100);
        chk("t5_no_commit", 32'(commitValid), 32'd0);
        chk("t5_robid_zero", 32'(issueRobId), 32'd0);
        rs(4'd2, 32'h55); queryId1 = 4'd2; tick();
        tick();
        chk("t5_stale_ignored", 32'(queryReady1), 32'd0);
        chk("t5_no_commit_later", 32'(commitValid), 32'd0);

        // 6: store retirement, then reset mid-stream
        do_reset();
        issue(2'd1, 5'd0, 0, 0); tick();
        lsb(4'd0, 32'h0); tick();
        tick();
        chk("t6_store", 32'(storeCommit), 32'd1);
        chk("t6_store_id", 32'(commitRobId), 32'd0);
        chk("t6_store_no_cv", 32'(commitValid), 32'd0);
        for (int i = 0; i < 4; i++) begin issue(2'd0, 5'(i + 1), 0, 0); tick(); end
        rs(4'd2, 32'h7); lsb(4'd3, 32'h8); tick();
        resetIn = 0; issue(2'd0, 5'd3, 0, 0); rs(4'd1, 32'h9); tick();
        resetIn = 1; queryId1 = 4'd2; tick();
        chk("t6_rst_no_commit", 32'(commitValid), 32'd0);
        chk("t6_rst_robid", 32'(issueRobId), 32'd0);
        chk("t6_rst_query", 32'(queryReady1), 32'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 500; c++) begin
            issueValid     = (c >= 400 || mq.size() < 15) && ($urandom_range(0, 99) < 60);
            issueType      = 2'($urandom_range(0, 3));
            issueRd        = 5'($urandom);
            issuePredTaken = 1'($urandom);
            issueAltPc     = $urandom;
            rsUpdate       = 1'($urandom);
            rsRobId        = 4'($urandom);
            rsVal          = $urandom;
            lsbUpdate      = 1'($urandom);
            lsbRobId       = 4'($urandom);
            lsbVal         = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                rsRobId = mq[$urandom_range(0, mq.size() - 1)].id;
            if ($urandom_range(0, 3) == 0) lsbRobId = rsRobId;
            queryId1 = 4'($urandom);
            queryId2 = 4'($urandom);
            resetIn  = ($urandom_range(0, 199) != 0);
            tick();
            resetIn = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
